bilinear_fetch2x2: RTL

- Read-side client of the 8-bit single-clock 1R/1W on-chip pixel RAM in the bilinear DSA.
- Accepts one source coordinate per request: integer x/y plus fractional weights.
- Issues four sequential reads for the 2×2 neighbourhood (p00, p01, p10, p11) and absorbs the RAM's 1-cycle registered read latency.
- Presents the quad plus the fractional weights to the interpolation datapath over a valid/ready handshake.

---
 rtl/bilinear_pkg.sv | 27 ++
 rtl/bfetch_addr_gen.sv | 58 +++++
 rtl/bilinear_fetch2x2.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bilinear_pkg.sv
// bilinear_pkg: shared types and default widths for the bilinear 2x2 fetch path.
package bilinear_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int COORD_W_DEF = 8;
    localparam int FRAC_W_DEF  = 8;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A0    = 3'd1,
        A1    = 3'd2,
        A2    = 3'd3,
        A3    = 3'd4,
        DRAIN = 3'd5,
        OUT   = 3'd6
    } fetch_state_t;

    typedef struct packed {
        pixel_t p00;
        pixel_t p01;
        pixel_t p10;
        pixel_t p11;
    } quad_t;

endpackage

// File: rtl/bfetch_addr_gen.sv
// bfetch_addr_gen: combinational neighbour-coordinate generation and the four
// 2x2 read addresses. Edge clamping is compiled in with BFETCH_EDGE_CLAMP_EN;
// without it x+1 / y+1 are used unconditionally and img_h_i is ignored.
// All address arithmetic wraps modulo 2^ADDR_W.
module bfetch_addr_gen
    import bilinear_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] img_w_i,
    input  logic [COORD_W-1:0] img_h_i,
    input  logic [ADDR_W-1:0]  base_i,
    output logic [ADDR_W-1:0]  a00_o,
    output logic [ADDR_W-1:0]  a01_o,
    output logic [ADDR_W-1:0]  a10_o,
    output logic [ADDR_W-1:0]  a11_o
);

    logic [ADDR_W-1:0] x0;
    logic [ADDR_W-1:0] y0;
    logic [ADDR_W-1:0] x1;
    logic [ADDR_W-1:0] y1;
    logic [ADDR_W-1:0] r0;
    logic [ADDR_W-1:0] r1;

    assign x0 = ADDR_W'(x_i);
    assign y0 = ADDR_W'(y_i);

`ifdef BFETCH_EDGE_CLAMP_EN
    // One extra bit so x+1 never overflows before the comparison.
    logic [COORD_W:0] xp1;
    logic [COORD_W:0] yp1;

    assign xp1 = {1'b0, x_i} + (COORD_W+1)'(1);
    assign yp1 = {1'b0, y_i} + (COORD_W+1)'(1);
    // Border pixels replicate: a neighbour past the edge falls back to x / y.
    assign x1  = (xp1 >= {1'b0, img_w_i}) ? x0 : ADDR_W'(xp1);
    assign y1  = (yp1 >= {1'b0, img_h_i}) ? y0 : ADDR_W'(yp1);
`else
    // Caller guarantees in-range coordinates; image height plays no part.
    logic unused_img_h;
    assign unused_img_h = ^img_h_i;
    assign x1 = x0 + ADDR_W'(1);
    assign y1 = y0 + ADDR_W'(1);
`endif

    assign r0 = base_i + y0 * ADDR_W'(img_w_i);
    assign r1 = base_i + y1 * ADDR_W'(img_w_i);

    assign a00_o = r0 + x0;
    assign a01_o = r0 + x1;
    assign a10_o = r1 + x0;
    assign a11_o = r1 + x1;

endmodule

// File: rtl/bilinear_fetch2x2.sv
// bilinear_fetch2x2: read-side client of the 1R/1W pixel RAM. Accepts one
// coordinate per request, issues four sequential reads (p00, p01, p10, p11),
// absorbs the 1-cycle registered read latency and presents the quad plus the
// fractional weights on a valid/ready output.
// Optional feature macro: BFETCH_EDGE_CLAMP_EN (right/bottom edge clamping).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// req_ready is high only in IDLE; out_valid is high only in OUT, and every
// out_* signal is held stable from out_valid rising until the transfer.
module bilinear_fetch2x2
    import bilinear_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic [FRAC_W-1:0]  req_fx,
    input  logic [FRAC_W-1:0]  req_fy,
    input  logic [COORD_W-1:0] img_w,
    input  logic [COORD_W-1:0] img_h,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [7:0]         mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_p00,
    output logic [7:0]         out_p01,
    output logic [7:0]         out_p10,
    output logic [7:0]         out_p11,
    output logic [FRAC_W-1:0]  out_fx,
    output logic [FRAC_W-1:0]  out_fy,
    output logic               busy,
    output fetch_state_t       dbg_state
);

    fetch_state_t      state_q, state_d;

    logic [ADDR_W-1:0] a00_d, a01_d, a10_d, a11_d;
    logic [ADDR_W-1:0] a00_q, a01_q, a10_q, a11_q;
    logic [FRAC_W-1:0] fx_q, fy_q;
    pixel_t            p00_q, p01_q, p10_q;
    quad_t             quad_q;
    logic [FRAC_W-1:0] out_fx_q, out_fy_q;
    logic              accept;

    assign accept = (state_q == IDLE) && req_valid;

    bfetch_addr_gen #(
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .x_i     (req_x),
        .y_i     (req_y),
        .img_w_i (img_w),
        .img_h_i (img_h),
        .base_i  (base_addr),
        .a00_o   (a00_d),
        .a01_o   (a01_d),
        .a10_o   (a10_d),
        .a11_o   (a11_d)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: fixed four-read walk, one drain cycle, then hold in OUT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = A0;
            A0:      state_d = A1;
            A1:      state_d = A2;
            A2:      state_d = A3;
            A3:      state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses and weights are frozen at acceptance so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a00_q <= '0;
            a01_q <= '0;
            a10_q <= '0;
            a11_q <= '0;
            fx_q  <= '0;
            fy_q  <= '0;
        end else if (accept) begin
            a00_q <= a00_d;
            a01_q <= a01_d;
            a10_q <= a10_d;
            a11_q <= a11_d;
            fx_q  <= req_fx;
            fy_q  <= req_fy;
        end
    end

    // Read address is a pure function of state and registered addresses.
    always_comb begin
        mem_raddr = a11_q;
        case (state_q)
            A0:      mem_raddr = a00_q;
            A1:      mem_raddr = a01_q;
            A2:      mem_raddr = a10_q;
            default: mem_raddr = a11_q;
        endcase
    end

    // Stage returning pixels; the visible quad updates in one step at the end of DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00_q    <= '0;
            p01_q    <= '0;
            p10_q    <= '0;
            quad_q   <= '0;
            out_fx_q <= '0;
            out_fy_q <= '0;
        end else begin
            case (state_q)
                A1:    p00_q <= mem_rdata;
                A2:    p01_q <= mem_rdata;
                A3:    p10_q <= mem_rdata;
                DRAIN: begin
                    quad_q.p00 <= p00_q;
                    quad_q.p01 <= p01_q;
                    quad_q.p10 <= p10_q;
                    quad_q.p11 <= mem_rdata;
                    out_fx_q   <= fx_q;
                    out_fy_q   <= fy_q;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_p00   = quad_q.p00;
    assign out_p01   = quad_q.p01;
    assign out_p10   = quad_q.p10;
    assign out_p11   = quad_q.p11;
    assign out_fx    = out_fx_q;
    assign out_fy    = out_fy_q;
    assign dbg_state = state_q;

endmodule
